// File: rtl/digit_template_match.sv
// Scores a binarized 16x16 sample against the ten digit templates, one row per cycle.
// It then picks the digit with the highest bit-agreement count.
module digit_template_match #(
  parameter int MIN_SCORE = 192,
  parameter int SCORE_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [3:0]         row_addr,
  input  logic [15:0]        sample_row,
  input  logic [15:0]        char_0,
  input  logic [15:0]        char_1,
  input  logic [15:0]        char_2,
  input  logic [15:0]        char_3,
  input  logic [15:0]        char_4,
  input  logic [15:0]        char_5,
  input  logic [15:0]        char_6,
  input  logic [15:0]        char_7,
  input  logic [15:0]        char_8,
  input  logic [15:0]        char_9,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [3:0]         digit,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] MIN_SCORE_W = SCORE_W'(MIN_SCORE);

  typedef enum logic [1:0] {IDLE, SCAN, SELECT, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [SCORE_W-1:0] acc [10];
  logic [SCORE_W-1:0] best, best_nxt;
  logic [3:0]         best_idx, best_idx_nxt;
  logic [SCORE_W-1:0] acc_sel;
  logic [15:0]        tmpl [10];

  function automatic logic [4:0] agree_count(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq;
    logic [4:0]  n;
    eq = ~(a ^ b);
    n  = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, eq[i]};
    return n;
  endfunction

  assign tmpl[0] = char_0;
  assign tmpl[1] = char_1;
  assign tmpl[2] = char_2;
  assign tmpl[3] = char_3;
  assign tmpl[4] = char_4;
  assign tmpl[5] = char_5;
  assign tmpl[6] = char_6;
  assign tmpl[7] = char_7;
  assign tmpl[8] = char_8;
  assign tmpl[9] = char_9;

  assign row_addr = (state == SCAN) ? cnt : 4'd0;
  assign busy     = (state == SCAN) || (state == SELECT);
  assign done     = (state == DONE);

  // cnt doubles as the digit index while in SELECT
  always_comb begin
    acc_sel = '0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == 4'(k)) acc_sel = acc[k];
    end
  end

  always_comb begin
    state_nxt    = state;
    best_nxt     = best;
    best_idx_nxt = best_idx;
    case (state)
      IDLE:   if (start) state_nxt = SCAN;
      SCAN:   if (cnt == 4'd15) state_nxt = SELECT;
      SELECT: begin
        // strict compare keeps the lowest digit on ties
        if (cnt == 4'd0 || acc_sel > best) begin
          best_nxt     = acc_sel;
          best_idx_nxt = cnt;
        end
        if (cnt == 4'd9) state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      valid    <= 1'b0;
      digit    <= 4'hF;
      score    <= '0;
      for (int k = 0; k < 10; k++) acc[k] <= '0;
    end else begin
      state    <= state_nxt;
      best     <= best_nxt;
      best_idx <= best_idx_nxt;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          for (int k = 0; k < 10; k++) acc[k] <= '0;
        end
        SCAN: begin
          cnt <= cnt + 4'd1;
          for (int k = 0; k < 10; k++)
            acc[k] <= acc[k] + SCORE_W'(agree_count(sample_row, tmpl[k]));
        end
        SELECT: begin
          cnt <= cnt + 4'd1;
          // result is latched on the edge into DONE so it is visible with done
          if (cnt == 4'd9) begin
            score <= best_nxt;
            valid <= (best_nxt >= MIN_SCORE_W);
            digit <= (best_nxt >= MIN_SCORE_W) ? best_idx_nxt : 4'hF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
